// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// Groups the request, debug and memory-pin signals of mem_bus_arbiter.
//   slave  : the arbiter's view (takes requests and memory read data, drives
//            CPU_HOLD, the debug response and the MEM_* pins)
//   master : the requester/memory side (CPU controller, debug port, SRAM)
// Signals:
//   WAIT_CFG          wait states per access, sampled at grant
//   CPU_REQ..BYTEX    CPU request, address, write data and access type
//   CPU_HOLD          stall back to the CPU phase sequencer
//   DBG_REQ..DBG_WE   debug request, word address, write data, direction
//   DBG_ACK, DBG_DIN  debug completion pulse and read data
//   MEM_DIN           memory read data
//   MEM_ADDR..MEM_OEN registered memory address, data and active-low strobes
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
   parameter int WAIT_W = 3
);
   logic [WAIT_W-1:0] WAIT_CFG;
   logic              CPU_REQ;
   logic [15:0]       CPU_ADDR;
   logic [15:0]       CPU_DOUT;
   logic              CPU_RDX;
   logic              CPU_WRX;
   logic              CPU_BYTEX;
   logic              CPU_HOLD;
   logic              DBG_REQ;
   logic [15:0]       DBG_ADDR;
   logic [15:0]       DBG_DOUT;
   logic              DBG_WE;
   logic              DBG_ACK;
   logic [15:0]       DBG_DIN;
   logic [15:0]       MEM_DIN;
   logic [15:0]       MEM_ADDR;
   logic [15:0]       MEM_DOUT;
   logic              MEM_RDN;
   logic              MEM_WRN0;
   logic              MEM_WRN1;
   logic              MEM_OEN;

   modport slave (
      input  WAIT_CFG,
      input  CPU_REQ, CPU_ADDR, CPU_DOUT, CPU_RDX, CPU_WRX, CPU_BYTEX,
      output CPU_HOLD,
      input  DBG_REQ, DBG_ADDR, DBG_DOUT, DBG_WE,
      output DBG_ACK, DBG_DIN,
      input  MEM_DIN,
      output MEM_ADDR, MEM_DOUT, MEM_RDN, MEM_WRN0, MEM_WRN1, MEM_OEN
   );

   modport master (
      output WAIT_CFG,
      output CPU_REQ, CPU_ADDR, CPU_DOUT, CPU_RDX, CPU_WRX, CPU_BYTEX,
      input  CPU_HOLD,
      output DBG_REQ, DBG_ADDR, DBG_DOUT, DBG_WE,
      input  DBG_ACK, DBG_DIN,
      output MEM_DIN,
      input  MEM_ADDR, MEM_DOUT, MEM_RDN, MEM_WRN0, MEM_WRN1, MEM_OEN
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares the external 16-bit memory bus between the CPU bus controller and
// the debug/monitor port. The CPU has priority; a starvation counter hands
// the bus to the debug port after STARVE_LIMIT consecutive lost arbitrations
// while both were requesting. Every access lasts 1+WAIT_CFG cycles and is
// always followed by at least one strobe-free cycle (IDLE or DBG_DONE).
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous, active-low reset; drops all strobes immediately
//   bus    mem_bus_arbiter_if.slave (requests, debug response, MEM_* pins)
// Parameters:
//   WAIT_W        width of WAIT_CFG and of the wait-state counter
//   STARVE_LIMIT  lost arbitrations before debug wins (0..7)
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int WAIT_W       = 3,
   parameter int STARVE_LIMIT = 3
) (
   input logic              CLK,
   input logic              RESET,
   mem_bus_arbiter_if.slave bus
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CPU_ACC  = 2'd1;
   localparam logic [1:0] ST_DBG_ACC  = 2'd2;
   localparam logic [1:0] ST_DBG_DONE = 2'd3;

   localparam logic [2:0] STARVE_LIM_C = 3'(STARVE_LIMIT);
   localparam logic [2:0] STARVE_MAX_C = 3'd7;

   // Strobe vector {RDN, OEN, WRN1, WRN0} for one access. A write wins over
   // a simultaneous read; neither gives an access with no strobes at all.
   // For byte writes only the lane selected by a0 is strobed.
   function automatic logic [3:0] enc_strobes(input logic rd,
                                              input logic wr,
                                              input logic byte_acc,
                                              input logic a0);
      logic [3:0] s;
      if (wr) begin
         s = {1'b1, 1'b0, byte_acc & ~a0, byte_acc & a0};
      end else if (rd) begin
         s = 4'b0111;
      end else begin
         s = 4'b1111;
      end
      return s;
   endfunction

   logic [1:0]        state_r,     state_nxt_s;
   logic [WAIT_W-1:0] wcnt_r,      wcnt_nxt_s;
   logic [2:0]        starve_r,    starve_nxt_s;
   logic [15:0]       mem_addr_r,  mem_addr_nxt_s;
   logic [15:0]       mem_dout_r,  mem_dout_nxt_s;
   logic [15:0]       dbg_din_r,   dbg_din_nxt_s;
   logic              dbg_ack_r,   dbg_ack_nxt_s;
   logic              dbg_rd_r,    dbg_rd_nxt_s;
   logic [3:0]        strb_r,      strb_nxt_s;   // {RDN, OEN, WRN1, WRN0}

   logic              dbg_win_s;
   logic              cpu_win_s;
   logic              acc_last_s;

   // Arbitration decision, only meaningful in IDLE.
   always_comb begin
      dbg_win_s  = bus.DBG_REQ & (~bus.CPU_REQ | (starve_r == STARVE_LIM_C));
      cpu_win_s  = bus.CPU_REQ & ~dbg_win_s;
      acc_last_s = (wcnt_r == '0);
   end

   // Next-state and next-output computation for every register.
   always_comb begin
      state_nxt_s    = state_r;
      wcnt_nxt_s     = wcnt_r;
      starve_nxt_s   = starve_r;
      mem_addr_nxt_s = mem_addr_r;
      mem_dout_nxt_s = mem_dout_r;
      dbg_din_nxt_s  = dbg_din_r;
      dbg_ack_nxt_s  = 1'b0;
      dbg_rd_nxt_s   = dbg_rd_r;
      strb_nxt_s     = strb_r;

      case (state_r)
         ST_IDLE: begin
            strb_nxt_s = 4'b1111;
            if (dbg_win_s) begin
               state_nxt_s    = ST_DBG_ACC;
               wcnt_nxt_s     = bus.WAIT_CFG;
               starve_nxt_s   = 3'd0;
               mem_addr_nxt_s = bus.DBG_ADDR;
               mem_dout_nxt_s = bus.DBG_DOUT;
               dbg_rd_nxt_s   = ~bus.DBG_WE;
               // Debug is always a word access: RDX = ~WE, WRX = WE.
               strb_nxt_s     = enc_strobes(~bus.DBG_WE, bus.DBG_WE, 1'b0, 1'b0);
            end else if (cpu_win_s) begin
               state_nxt_s    = ST_CPU_ACC;
               wcnt_nxt_s     = bus.WAIT_CFG;
               mem_addr_nxt_s = bus.CPU_ADDR;
               mem_dout_nxt_s = bus.CPU_DOUT;
               strb_nxt_s     = enc_strobes(bus.CPU_RDX, bus.CPU_WRX,
                                            bus.CPU_BYTEX, bus.CPU_ADDR[0]);
               // Debug lost while it was asking: count towards its forced win.
               if (bus.DBG_REQ && (starve_r != STARVE_MAX_C)) begin
                  starve_nxt_s = starve_r + 3'd1;
               end else begin
                  starve_nxt_s = starve_r;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end

         ST_CPU_ACC: begin
            if (acc_last_s) begin
               state_nxt_s = ST_IDLE;
               strb_nxt_s  = 4'b1111;
            end else begin
               wcnt_nxt_s  = wcnt_r - WAIT_W'(1'b1);
            end
         end

         ST_DBG_ACC: begin
            if (acc_last_s) begin
               state_nxt_s   = ST_DBG_DONE;
               strb_nxt_s    = 4'b1111;
               dbg_ack_nxt_s = 1'b1;
               // Capture read data on the final strobed edge; writes keep
               // the last read value.
               if (dbg_rd_r) begin
                  dbg_din_nxt_s = bus.MEM_DIN;
               end else begin
                  dbg_din_nxt_s = dbg_din_r;
               end
            end else begin
               wcnt_nxt_s = wcnt_r - WAIT_W'(1'b1);
            end
         end

         ST_DBG_DONE: begin
            state_nxt_s = ST_IDLE;
            strb_nxt_s  = 4'b1111;
         end

         default: begin
            state_nxt_s = ST_IDLE;
            strb_nxt_s  = 4'b1111;
         end
      endcase
   end

   // State, counters and registered bus outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_r    <= ST_IDLE;
         wcnt_r     <= '0;
         starve_r   <= 3'd0;
         mem_addr_r <= 16'h0000;
         mem_dout_r <= 16'h0000;
         dbg_din_r  <= 16'h0000;
         dbg_ack_r  <= 1'b0;
         dbg_rd_r   <= 1'b0;
         strb_r     <= 4'b1111;
      end else begin
         state_r    <= state_nxt_s;
         wcnt_r     <= wcnt_nxt_s;
         starve_r   <= starve_nxt_s;
         mem_addr_r <= mem_addr_nxt_s;
         mem_dout_r <= mem_dout_nxt_s;
         dbg_din_r  <= dbg_din_nxt_s;
         dbg_ack_r  <= dbg_ack_nxt_s;
         dbg_rd_r   <= dbg_rd_nxt_s;
         strb_r     <= strb_nxt_s;
      end
   end

   // HOLD releases in the last cycle of a CPU access so the phase
   // sequencer can advance on the same edge that ends the access.
   always_comb begin
      bus.CPU_HOLD = bus.CPU_REQ & ~((state_r == ST_CPU_ACC) & acc_last_s);
   end

   assign bus.MEM_ADDR = mem_addr_r;
   assign bus.MEM_DOUT = mem_dout_r;
   assign bus.MEM_RDN  = strb_r[3];
   assign bus.MEM_OEN  = strb_r[2];
   assign bus.MEM_WRN1 = strb_r[1];
   assign bus.MEM_WRN0 = strb_r[0];
   assign bus.DBG_ACK  = dbg_ack_r;
   assign bus.DBG_DIN  = dbg_din_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter: a table of single-requester accesses
// with hand-computed strobes, lengths and debug data, plus hand-written
// sequences for starvation, reset mid-access and mid-access request drop.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   logic CLK;
   logic RESET;

   mem_bus_arbiter_if #(.WAIT_W(3)) bus ();

   mem_bus_arbiter #(.WAIT_W(3), .STARVE_LIMIT(3)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [3:0] strb;
   assign strb = {bus.MEM_RDN, bus.MEM_OEN, bus.MEM_WRN1, bus.MEM_WRN0};

   typedef struct {
      logic        is_dbg;
      logic [15:0] addr;
      logic [15:0] dout;
      logic        rdx;
      logic        wrx;
      logic        bytex;
      logic        we;
      logic [2:0]  wcfg;
      logic [15:0] mdin;
      logic [3:0]  exp_strb;   // {RDN, OEN, WRN1, WRN0}
      int          exp_cyc;
      logic [15:0] exp_din;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(posedge CLK); #1;
      bus.WAIT_CFG = v.wcfg;
      bus.MEM_DIN  = v.mdin;
      if (v.is_dbg) begin
         bus.DBG_ADDR = v.addr;
         bus.DBG_DOUT = v.dout;
         bus.DBG_WE   = v.we;
         bus.DBG_REQ  = 1'b1;
      end else begin
         bus.CPU_ADDR  = v.addr;
         bus.CPU_DOUT  = v.dout;
         bus.CPU_RDX   = v.rdx;
         bus.CPU_WRX   = v.wrx;
         bus.CPU_BYTEX = v.bytex;
         bus.CPU_REQ   = 1'b1;
      end
      // request cycle, bus still idle
      @(negedge CLK);
      chk($sformatf("v%0d_pre_strb", idx), 32'(strb), 32'hF);
      if (!v.is_dbg) chk($sformatf("v%0d_pre_hold", idx), 32'(bus.CPU_HOLD), 32'h1);
      for (int k = 0; k < v.exp_cyc; k++) begin
         @(negedge CLK);
         chk($sformatf("v%0d_strb_c%0d", idx, k), 32'(strb), 32'(v.exp_strb));
         chk($sformatf("v%0d_addr_c%0d", idx, k), 32'(bus.MEM_ADDR), 32'(v.addr));
         if (k == 0) chk($sformatf("v%0d_dout", idx), 32'(bus.MEM_DOUT), 32'(v.dout));
         if (!v.is_dbg)
            chk($sformatf("v%0d_hold_c%0d", idx, k), 32'(bus.CPU_HOLD),
                (k == v.exp_cyc - 1) ? 32'h0 : 32'h1);
         else
            chk($sformatf("v%0d_ack_c%0d", idx, k), 32'(bus.DBG_ACK), 32'h0);
      end
      @(posedge CLK); #1;
      bus.CPU_REQ = 1'b0;
      bus.DBG_REQ = 1'b0;
      @(negedge CLK);
      chk($sformatf("v%0d_post_strb", idx), 32'(strb), 32'hF);
      if (v.is_dbg) begin
         chk($sformatf("v%0d_ack", idx), 32'(bus.DBG_ACK), 32'h1);
         chk($sformatf("v%0d_din", idx), 32'(bus.DBG_DIN), 32'(v.exp_din));
         @(negedge CLK);
         chk($sformatf("v%0d_ack_drop", idx), 32'(bus.DBG_ACK), 32'h0);
         chk($sformatf("v%0d_idle_strb", idx), 32'(strb), 32'hF);
      end else begin
         chk($sformatf("v%0d_post_hold", idx), 32'(bus.CPU_HOLD), 32'h0);
      end
   endtask

   initial begin
      logic [15:0] seq [8];
      logic [15:0] exp_seq [8];
      int          n;
      int          acks;
      logic        prev_idle;

      // is_dbg addr dout rdx wrx byte we wcfg mdin strb cyc din
      vecs[0] = '{1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 4'b0111, 1, 16'h0000};
      vecs[1] = '{1'b0, 16'h0101, 16'h5A00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0000, 4'b1001, 3, 16'h0000};
      vecs[2] = '{1'b1, 16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 16'hBEEF, 4'b0111, 2, 16'hBEEF};
      vecs[3] = '{1'b0, 16'h0100, 16'h00A5, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 4'b1010, 2, 16'h0000};
      vecs[4] = '{1'b0, 16'h4000, 16'h9876, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 4'b1000, 1, 16'h0000};
      vecs[5] = '{1'b0, 16'h0002, 16'h3C3C, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0000, 4'b1000, 2, 16'h0000};
      vecs[6] = '{1'b0, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0000, 4'b1111, 3, 16'h0000};
      vecs[7] = '{1'b1, 16'h0300, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h2222, 4'b1000, 1, 16'hBEEF};
      vecs[8] = '{1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'hCAFE, 4'b0111, 4, 16'hCAFE};

      exp_seq = '{16'hC000, 16'hC000, 16'hC000, 16'hD000,
                  16'hC000, 16'hC000, 16'hC000, 16'hD000};

      RESET         = 1'b0;
      bus.WAIT_CFG  = 3'd0;
      bus.CPU_REQ   = 1'b0;
      bus.CPU_ADDR  = 16'h0000;
      bus.CPU_DOUT  = 16'h0000;
      bus.CPU_RDX   = 1'b0;
      bus.CPU_WRX   = 1'b0;
      bus.CPU_BYTEX = 1'b0;
      bus.DBG_REQ   = 1'b0;
      bus.DBG_ADDR  = 16'h0000;
      bus.DBG_DOUT  = 16'h0000;
      bus.DBG_WE    = 1'b0;
      bus.MEM_DIN   = 16'h0000;

      // reset values
      repeat (2) @(negedge CLK);
      chk("rst_strb", 32'(strb), 32'hF);
      chk("rst_addr", 32'(bus.MEM_ADDR), 32'h0);
      chk("rst_dout", 32'(bus.MEM_DOUT), 32'h0);
      chk("rst_din",  32'(bus.DBG_DIN), 32'h0);
      chk("rst_ack",  32'(bus.DBG_ACK), 32'h0);
      chk("rst_hold", 32'(bus.CPU_HOLD), 32'h0);
      RESET = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // both requesters held: C C C D C C C D with turnaround between
      @(posedge CLK); #1;
      bus.WAIT_CFG  = 3'd0;
      bus.CPU_ADDR  = 16'hC000;
      bus.CPU_RDX   = 1'b1;
      bus.CPU_WRX   = 1'b0;
      bus.CPU_BYTEX = 1'b0;
      bus.DBG_ADDR  = 16'hD000;
      bus.DBG_WE    = 1'b0;
      bus.CPU_REQ   = 1'b1;
      bus.DBG_REQ   = 1'b1;
      n = 0;
      prev_idle = 1'b1;
      for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
         @(negedge CLK);
         if (strb != 4'hF) begin
            chk("starve_turnaround", 32'(prev_idle), 32'h1);
            if (prev_idle) begin
               seq[n] = bus.MEM_ADDR;
               n++;
            end
         end
         prev_idle = (strb == 4'hF);
      end
      chk("starve_grant_count", 32'(n), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < n) chk($sformatf("starve_grant%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
      @(posedge CLK); #1;
      bus.CPU_REQ = 1'b0;
      bus.DBG_REQ = 1'b0;
      repeat (4) @(negedge CLK);
      chk("starve_end_strb", 32'(strb), 32'hF);

      // DBG read: request dropped and WAIT_CFG changed mid-access
      @(posedge CLK); #1;
      bus.WAIT_CFG = 3'd2;
      bus.DBG_ADDR = 16'h0A0A;
      bus.DBG_WE   = 1'b0;
      bus.MEM_DIN  = 16'h1357;
      bus.DBG_REQ  = 1'b1;
      @(posedge CLK); #1;                 // grant edge
      bus.DBG_REQ  = 1'b0;
      bus.WAIT_CFG = 3'd7;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk($sformatf("drop_strb_c%0d", k), 32'(strb), 32'h7);
      end
      @(negedge CLK);
      chk("drop_end_strb", 32'(strb), 32'hF);
      chk("drop_ack", 32'(bus.DBG_ACK), 32'h1);
      chk("drop_din", 32'(bus.DBG_DIN), 32'h1357);
      acks = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         if (bus.DBG_ACK) acks++;
         chk($sformatf("drop_quiet_c%0d", k), 32'(strb), 32'hF);
      end
      chk("drop_no_second_ack", 32'(acks), 32'd0);

      // reset in the 2nd cycle of a 4-cycle debug write
      @(posedge CLK); #1;
      bus.WAIT_CFG = 3'd3;
      bus.DBG_ADDR = 16'h7777;
      bus.DBG_DOUT = 16'hA5A5;
      bus.DBG_WE   = 1'b1;
      bus.DBG_REQ  = 1'b1;
      @(negedge CLK);                      // request cycle
      @(negedge CLK);
      chk("rstmid_c0_strb", 32'(strb), 32'h8);
      @(negedge CLK);
      chk("rstmid_c1_strb", 32'(strb), 32'h8);
      RESET = 1'b0;
      #1;
      chk("rstmid_async_strb", 32'(strb), 32'hF);
      chk("rstmid_async_addr", 32'(bus.MEM_ADDR), 32'h0);
      chk("rstmid_async_ack", 32'(bus.DBG_ACK), 32'h0);
      repeat (2) begin
         @(negedge CLK);
         chk("rstmid_hold_ack", 32'(bus.DBG_ACK), 32'h0);
         chk("rstmid_hold_strb", 32'(strb), 32'hF);
      end
      RESET = 1'b1;
      @(negedge CLK);                      // regrant happened on the posedge
      chk("regrant_strb", 32'(strb), 32'h8);
      chk("regrant_addr", 32'(bus.MEM_ADDR), 32'h7777);
      chk("regrant_dout", 32'(bus.MEM_DOUT), 32'hA5A5);
      repeat (3) @(negedge CLK);
      chk("regrant_c3_strb", 32'(strb), 32'h8);
      chk("regrant_c3_ack", 32'(bus.DBG_ACK), 32'h0);
      @(negedge CLK);
      chk("regrant_done_strb", 32'(strb), 32'hF);
      chk("regrant_ack", 32'(bus.DBG_ACK), 32'h1);
      chk("regrant_din_kept", 32'(bus.DBG_DIN), 32'h0);
      @(posedge CLK); #1;
      bus.DBG_REQ = 1'b0;
      @(negedge CLK);
      chk("regrant_ack_drop", 32'(bus.DBG_ACK), 32'h0);
      chk("regrant_idle_strb", 32'(strb), 32'hF);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the external 16-bit memory bus between the CPU bus controller and the debug/monitor port.
- Sequences each access through wait states and owns the final registered bus strobes.
- The CPU has priority. A starvation counter guarantees that debug accesses make progress.
- Sits between the CPU bus controller outputs and the SRAM/IO pins.

Parameters:
- WAIT_W, 3, width of the wait-state count and of WAIT_CFG.
- STARVE_LIMIT, 3, number of consecutive arbitration losses after which DBG wins; maximum value 7.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- WAIT_CFG  in  WAIT_W  extra cycles per access; sampled at grant.
- CPU_REQ  in  1  CPU requests the bus; held until CPU_HOLD is low.
- CPU_ADDR  in  16  CPU address.
- CPU_DOUT  in  16  CPU write data.
- CPU_RDX  in  1  CPU read.
- CPU_WRX  in  1  CPU write.
- CPU_BYTEX  in  1  CPU byte access; lane chosen by CPU_ADDR[0].
- CPU_HOLD  out  1  stall to the CPU phase sequencer.
- DBG_REQ  in  1  debug requests the bus; held until DBG_ACK.
- DBG_ADDR  in  16  debug word address.
- DBG_DOUT  in  16  debug write data.
- DBG_WE  in  1  1 = write, 0 = read.
- DBG_ACK  out  1  one-cycle completion pulse.
- DBG_DIN  out  16  debug read data; valid when DBG_ACK is high.
- MEM_DIN  in  16  memory read data.
- MEM_ADDR  out  16  registered address.
- MEM_DOUT  out  16  registered write data.
- MEM_RDN  out  1  active-low read strobe.
- MEM_WRN0  out  1  active-low low-byte write strobe.
- MEM_WRN1  out  1  active-low high-byte write strobe.
- MEM_OEN  out  1  active-low data-bus output enable.

Behaviour:
- Reset values (RESET=0, asynchronous):
  - state=IDLE, WCNT=0, STARVE=0.
  - MEM_ADDR=0, MEM_DOUT=0, DBG_DIN=0, DBG_ACK=0.
  - MEM_RDN=1, MEM_WRN0=1, MEM_WRN1=1, MEM_OEN=1.
  - Reset mid-access drops all strobes immediately. No ACK is issued.
- States: IDLE, CPU_ACC, DBG_ACC, DBG_DONE.
- IDLE:
  - All strobes high.
  - Arbitration:
    - DBG wins if DBG_REQ=1 and (CPU_REQ=0 or STARVE==STARVE_LIMIT).
    - Otherwise CPU wins if CPU_REQ=1.
    - Otherwise stay in IDLE.
  - On the winning edge: WCNT<=WAIT_CFG, and the winner's address/data/strobes are registered onto MEM_*.
  - STARVE update:
    - Increments (saturating) when both requesters are present and CPU wins.
    - Clears on any DBG grant.
    - Otherwise unchanged.
- Strobe encoding, registered while in an ACC state:
  - Read: MEM_RDN=0, MEM_OEN=1.
  - Write: MEM_OEN=0.
    - MEM_WRN0 = BYTEX & ADDR[0].
    - MEM_WRN1 = BYTEX & ~ADDR[0].
  - RDX=WRX=1: the write takes precedence.
  - RDX=WRX=0: no strobes, and the access still consumes its cycles.
  - DBG is always a word access (BYTEX=0).
  - Byte lane placement of data is the CPU side's responsibility. MEM_DOUT passes data through unchanged.
- Access timing:
  - CPU_ACC/DBG_ACC last 1+WAIT_CFG cycles. WCNT decrements each cycle; the access ends in the cycle where WCNT==0.
  - Next state after the end: CPU_ACC goes to IDLE; DBG_ACC goes to DBG_DONE.
  - WAIT_CFG changes mid-access are ignored.
- DBG read data: DBG_DIN<=MEM_DIN on the final DBG_ACC edge. Unchanged on writes.
- DBG_DONE:
  - Strobes high, DBG_ACK=1 for exactly one cycle, then IDLE.
- Bus turnaround: at least one strobe-free cycle between any two accesses, via IDLE or DBG_DONE.
- CPU_HOLD (combinational) = CPU_REQ & ~(state==CPU_ACC & WCNT==0).
- Latency:
  - CPU request with bus idle: strobes asserted the cycle after the request; HOLD low after 1+WAIT_CFG cycles.
  - DBG: ACK follows 2+WAIT_CFG cycles after grant.
- Request withdrawal:
  - A request dropped in IDLE before grant is forgotten.
  - A request dropped mid-access does not abort; the access completes. DBG_ACK still pulses.
- Simultaneous requests with STARVE<STARVE_LIMIT: CPU wins.

Test Plan:
- CPU word read, WAIT_CFG=0, CPU_ADDR=0x1234 -> MEM_RDN low for 1 cycle with MEM_ADDR=0x1234; CPU_HOLD high 1 cycle, then low; then IDLE.
- CPU byte write, ADDR=0x0101, WAIT_CFG=2 -> MEM_WRN1=0, MEM_WRN0=1, MEM_OEN=0 for 3 cycles; a strobe-free cycle follows.
- DBG read alone, ADDR=0x0200, MEM_DIN=0xBEEF, WAIT_CFG=1 -> 2 read cycles; DBG_ACK pulses once with DBG_DIN=0xBEEF.
- Both requesters held continuously, STARVE_LIMIT=3 -> grant sequence CPU, CPU, CPU, DBG, CPU, ...; each access separated by ≥1 idle cycle.
- RESET low in the 2nd cycle of a 4-cycle write -> all strobes high asynchronously; no DBG_ACK; after release the arbiter returns to IDLE and regrants a pending request.
- DBG_REQ dropped mid DBG_ACC, and WAIT_CFG changed mid-access -> access completes with the original length; ACK pulses once; no second access.
